ifetch_prefetch_queue: RTL and testbench

IFETCH_PREFETCH_QUEUE -- requirements
Module: ifetch_prefetch_queue

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifq_fifo.sv | 69 ++++++
 rtl/ifetch_prefetch_queue.sv | 173 +++++++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// FSM encodings are fixed so external checkers can decode dbg_state directly.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DISCARD = 2'b10
  } ifq_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifq_fifo.sv
// Circular word/address store for the prefetch queue: pointers, count, full/empty.
// A push while full is accepted only together with a pop.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [31:0]                  wdata,
  input  logic [AW-1:0]                waddr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [31:0]                  head_word,
  output logic [AW-1:0]                head_addr,
  output logic [31:0]                  next_word
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   word_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_q + PW'(1);

  // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_nxt;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      word_q[wr_q] <= wdata;
      addr_q[wr_q] <= waddr;
    end
  end

  assign count     = cnt_q;
  assign head_word = word_q[rd_q];
  assign head_addr = addr_q[rd_q];
  assign next_word = word_q[rd_nxt];

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, redirect/discard handling, head presentation.
// Build option IFQ_BYPASS_EN lets an empty queue show the completing icache word directly.
module ifetch_prefetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_addr,
  input  logic                       CPU_stall,
  output logic                       icache_read,
  output logic [AW-1:0]              icache_addr,
  input  logic                       icache_stall,
  input  logic [31:0]                icache_rdata,
  input  logic                       deq,
  output logic                       q_valid,
  output logic [31:0]                q_word,
  output logic [AW-1:0]              q_addr,
  output logic                       q_next_valid,
  output logic [31:0]                q_next_word,
  output logic                       q_half,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: an icache request completes in any cycle with icache_read=1 and
  // icache_stall=0, and read/addr stay frozen until then; the head is consumed
  // in any cycle with q_valid=1, deq=1, CPU_stall=0 and no redirect.

  ifq_state_e    state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] target_q, target_d;
  logic          half_pend_q, half_pend_d;
  logic          half_q, half_d;

  logic [AW-1:0] redirect_tgt;
  logic          unused_addr_bit;
  logic          fire;
  logic          flush;
  logic          push;
  logic          fifo_pop;
  logic          byp_pop;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [31:0]   head_word;
  logic [AW-1:0] head_addr;

  assign redirect_tgt    = {redirect_addr[AW-1:2], 2'b00};
  assign unused_addr_bit = redirect_addr[0];

  assign icache_read = (state_q != ST_IDLE);
  assign icache_addr = fetch_addr_q;
  assign fire        = icache_read && !icache_stall;
  assign fifo_pop    = deq && !CPU_stall && !redirect && !empty;
  assign push        = (state_q == ST_FETCH) && fire && !redirect && !byp_pop;

`ifdef IFQ_BYPASS_EN
  logic byp_valid;
  assign byp_valid = (state_q == ST_FETCH) && empty && fire && !redirect;
  assign byp_pop   = byp_valid && deq && !CPU_stall;
  assign q_valid   = !empty || byp_valid;
  assign q_word    = empty ? icache_rdata : head_word;
  assign q_addr    = empty ? fetch_addr_q : head_addr;
  assign q_half    = empty ? (byp_valid && half_pend_q) : half_q;
`else
  assign byp_pop   = 1'b0;
  assign q_valid   = !empty;
  assign q_word    = head_word;
  assign q_addr    = head_addr;
  assign q_half    = half_q;
`endif

  assign q_next_valid = (count >= CW'(2));
  assign dbg_state    = state_q;
  assign dbg_count    = count;

  ifq_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .pop      (fifo_pop),
    .wdata    (icache_rdata),
    .waddr    (fetch_addr_q),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .head_word(head_word),
    .head_addr(head_addr),
    .next_word(q_next_word)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    half_pend_d  = half_pend_q;
    half_d       = half_q;
    flush        = 1'b0;
    if (fifo_pop) half_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          flush        = 1'b1;
          half_d       = 1'b0;
          fetch_addr_d = redirect_tgt;
          half_pend_d  = redirect_addr[1];
          state_d      = ST_FETCH;
        end else if (!full || fifo_pop) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (redirect) begin
          flush       = 1'b1;
          half_d      = 1'b0;
          half_pend_d = redirect_addr[1];
          // A stalled request cannot be withdrawn; park the target until it drains.
          if (icache_stall) begin
            target_d = redirect_tgt;
            state_d  = ST_DISCARD;
          end else begin
            fetch_addr_d = redirect_tgt;
          end
        end else if (fire) begin
          fetch_addr_d = fetch_addr_q + AW'(4);
          if (half_pend_q && push) half_d = 1'b1;
          half_pend_d = 1'b0;
          if ((int'(count) + 1 == DEPTH) && !fifo_pop) state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          flush       = 1'b1;
          half_d      = 1'b0;
          target_d    = redirect_tgt;
          half_pend_d = redirect_addr[1];
        end
        if (fire) begin
          fetch_addr_d = redirect ? redirect_tgt : target_q;
          state_d      = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= AW'(RESET_PC);
      target_q     <= '0;
      half_pend_q  <= 1'b0;
      half_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      half_pend_q  <= half_pend_d;
      half_q       <= half_d;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue: fill, streaming, redirects, stalls.
// Expectations adapt when IFQ_BYPASS_EN is defined for both bench and design.
module tb_ifetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          CPU_stall;
  logic          icache_read;
  logic [AW-1:0] icache_addr;
  logic          icache_stall;
  logic [31:0]   icache_rdata;
  logic          deq;
  logic          q_valid;
  logic [31:0]   q_word;
  logic [AW-1:0] q_addr;
  logic          q_next_valid;
  logic [31:0]   q_next_word;
  logic          q_half;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .CPU_stall    (CPU_stall),
    .icache_read  (icache_read),
    .icache_addr  (icache_addr),
    .icache_stall (icache_stall),
    .icache_rdata (icache_rdata),
    .deq          (deq),
    .q_valid      (q_valid),
    .q_word       (q_word),
    .q_addr       (q_addr),
    .q_next_valid (q_next_valid),
    .q_next_word  (q_next_word),
    .q_half       (q_half),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Icache model: each word is its address with a fixed tag in the upper half.
  assign icache_rdata = icache_addr ^ 32'h5A5A_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst           = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    CPU_stall     = 1'b0;
    icache_stall  = 1'b0;
    deq           = 1'b0;
    tick();
    tick();
    check("rst_read",   32'(icache_read),  32'(0));
    check("rst_qvalid", 32'(q_valid),      32'(0));
    check("rst_qnext",  32'(q_next_valid), 32'(0));
    check("rst_qhalf",  32'(q_half),       32'(0));
    check("rst_count",  32'(dbg_count),    32'(0));
    check("rst_state",  32'(dbg_state),    32'(0));
    check("rst_addr",   icache_addr,       32'h0);

    @(negedge clk);
    rst = 1'b1;

    // Fill from reset, no consumption
    tick();
    check("fill_read1",   32'(icache_read), 32'(1));
    check("fill_addr1",   icache_addr,      32'h0);
    check("fill_qvalid1", 32'(q_valid),     32'(BYP));
    tick();
    check("fill_qvalid2", 32'(q_valid),     32'(1));
    check("fill_qaddr2",  q_addr,           32'h0);
    check("fill_qword2",  q_word,           mem_word(32'h0));
    check("fill_count2",  32'(dbg_count),   32'(1));
    check("fill_addr2",   icache_addr,      32'h4);
    tick();
    check("fill_count3",  32'(dbg_count),    32'(2));
    check("fill_next3",   32'(q_next_valid), 32'(1));
    check("fill_nword3",  q_next_word,       mem_word(32'h4));
    check("fill_addr3",   icache_addr,       32'h8);
    tick();
    check("fill_count4",  32'(dbg_count),   32'(3));
    check("fill_addr4",   icache_addr,      32'hC);
    tick();
    check("full_count",   32'(dbg_count),   32'(4));
    check("full_read",    32'(icache_read), 32'(0));
    check("full_state",   32'(dbg_state),   32'(0));
    check("full_qaddr",   q_addr,           32'h0);
    tick();
    check("full_read_hold", 32'(icache_read), 32'(0));
    check("full_addr_next", icache_addr,      32'h10);

    // Continuous consumption: one fetch per cycle, head advances by 4
    deq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("strm_qaddr", q_addr,           32'(4 * (i + 1)));
      check("strm_qword", q_word,           mem_word(32'(4 * (i + 1))));
      check("strm_count", 32'(dbg_count),   32'(3));
      check("strm_read",  32'(icache_read), 32'(1));
      check("strm_iaddr", icache_addr,      32'(32'h10 + 4 * i));
    end

    // Stalled icache: request frozen while the head is still consumed
    icache_stall = 1'b1;
    tick();
    check("stl_count", 32'(dbg_count),   32'(2));
    check("stl_qaddr", q_addr,           32'h14);
    check("stl_iaddr", icache_addr,      32'h1C);
    check("stl_read",  32'(icache_read), 32'(1));

    // Redirect to 0x106 with 2 entries queued and a completing fetch
    icache_stall  = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 32'h106;
    tick();
    redirect = 1'b0;
    deq      = 1'b0;
    #1;
    check("rd106_count",  32'(dbg_count), 32'(0));
    check("rd106_qvalid", 32'(q_valid),   32'(BYP));
    check("rd106_qhalf",  32'(q_half),    32'(BYP));
    check("rd106_iaddr",  icache_addr,    32'h104);
    check("rd106_state",  32'(dbg_state), 32'(1));
    tick();
    check("half_qvalid", 32'(q_valid),   32'(1));
    check("half_qaddr",  q_addr,         32'h104);
    check("half_flag",   32'(q_half),    32'(1));
    check("half_qword",  q_word,         mem_word(32'h104));
    check("half_iaddr",  icache_addr,    32'h108);
    deq = 1'b1;
    tick();
    check("half_clr_qaddr", q_addr,         32'h108);
    check("half_clr_flag",  32'(q_half),    32'(0));
    check("half_clr_count", 32'(dbg_count), 32'(1));

    // CPU_stall blocks dequeue while fetching fills the queue
    CPU_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cst_qaddr", q_addr,           32'h108);
      check("cst_count", 32'(dbg_count),   32'(2 + i));
      check("cst_read",  32'(icache_read), 32'(i < 2));
    end
    CPU_stall = 1'b0;
    deq       = 1'b0;

    // Redirect to 0x20, stall it, then redirect to 0x80 while in flight
    redirect      = 1'b1;
    redirect_addr = 32'h20;
    tick();
    check("rd20_count", 32'(dbg_count), 32'(0));
    check("rd20_iaddr", icache_addr,    32'h20);
    check("rd20_state", 32'(dbg_state), 32'(1));
    redirect     = 1'b0;
    icache_stall = 1'b1;
    tick();
    check("rd20_hold_iaddr", icache_addr,      32'h20);
    check("rd20_hold_read",  32'(icache_read), 32'(1));
    redirect      = 1'b1;
    redirect_addr = 32'h80;
    tick();
    check("disc_state", 32'(dbg_state),   32'(2));
    check("disc_iaddr", icache_addr,      32'h20);
    check("disc_read",  32'(icache_read), 32'(1));
    redirect     = 1'b0;
    icache_stall = 1'b0;
    deq          = 1'b1;
    #1;
    check("disc_qvalid", 32'(q_valid), 32'(0));
    tick();
    check("disc_done_state", 32'(dbg_state), 32'(1));
    check("disc_done_iaddr", icache_addr,    32'h80);
    check("disc_done_count", 32'(dbg_count), 32'(0));
    check("disc_done_qval",  32'(q_valid),   32'(BYP));
`ifdef IFQ_BYPASS_EN
    check("byp_qword", q_word, mem_word(32'h80));
    check("byp_qaddr", q_addr, 32'h80);
`endif
    tick();
    exp_cnt = BYP ? 0 : 1;
    check("t80_count",  32'(dbg_count), 32'(exp_cnt));
    check("t80_qvalid", 32'(q_valid),   32'(1));
    check("t80_qaddr",  q_addr,         BYP ? 32'h84 : 32'h80);
    check("t80_qword",  q_word,         mem_word(BYP ? 32'h84 : 32'h80));
    check("t80_qhalf",  32'(q_half),    32'(0));
    check("t80_iaddr",  icache_addr,    32'h84);
    deq = 1'b0;
    tick();
    exp_cnt = BYP ? 1 : 2;
    check("t84_count", 32'(dbg_count), 32'(exp_cnt));
    check("t84_qaddr", q_addr,         BYP ? 32'h84 : 32'h80);
    check("t84_iaddr", icache_addr,    32'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
